// File: rtl/calc_pkg.sv
// Shared constants and types for the calculator sequencing controller.
package calc_pkg;

    // Datapath operation codes presented on op_code
    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MUL  = 2'd2;
    localparam logic [1:0] OP_PASS = 2'd3;

    // Digit code the 7-seg decoder renders as a dash (negative sign)
    localparam logic [3:0] DIG_DASH = 4'd10;

    // One shift-add-3 iteration per result bit
    localparam int BCD_ITER = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LATCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_CONVERT = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift
    function automatic logic [15:0] bcd_adjust(input logic [15:0] bcd);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/calc_seq_ctrl_key_debounce.sv
// Per-key synchroniser, debouncer and press detector. The key is active-low;
// press is a one-cycle pulse on each accepted 1->0 transition of the
// debounced level, so holding a key produces exactly one pulse.
module key_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          sync_prev;
    logic          deb;
    logic          deb_prev;
    logic [CW-1:0] cnt;

    // Synchronise the key, restart the count on any synced change, and accept
    // the new level once it has stayed put for DEB_CYCLES cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
            deb       <= 1'b1;
            deb_prev  <= 1'b1;
            cnt       <= '0;
        end else begin
            sync1     <= key_n;
            sync2     <= sync1;
            sync_prev <= sync2;
            deb_prev  <= deb;
            if (sync2 != sync_prev || sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press = deb_prev & ~deb;

endmodule

// File: rtl/calc_seq_ctrl.sv
// Sequencing controller for the switch-driven 5-bit calculator: debounced op
// keys start one operation at a time, the datapath result is captured after
// its latency, converted to BCD serially and published to the HEX digits.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int DEB_CYCLES = 500000,
    parameter int DP_LAT     = 1
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [9:0] SW,
    input  logic [2:0] KEY,
    output logic [1:0] op_code,
    output logic [4:0] op_a,
    output logic [4:0] op_b,
    input  logic [9:0] res_in,
    input  logic       neg_in,
    output logic [9:0] LEDR,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic       minus,
    output logic       busy,
    output logic       done
);

    localparam int WW = (DP_LAT > 0) ? $clog2(DP_LAT + 1) : 1;

    state_t        state;
    logic [2:0]    press;
    logic [1:0]    sel_op;
    logic [WW-1:0] wait_cnt;
    logic [3:0]    iter;
    logic [25:0]   shreg;
    logic [25:0]   shift_next;

    for (genvar k = 0; k < 3; k++) begin : g_key
        key_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk  (CLOCK_50),
            .rst_n(RESET_N),
            .key_n(KEY[k]),
            .press(press[k])
        );
    end

    // KEY0 wins over KEY1 over KEY2 when presses land in the same cycle
    always_comb begin
        sel_op = OP_MUL;
        if (press[0]) begin
            sel_op = OP_ADD;
        end else if (press[1]) begin
            sel_op = OP_SUB;
        end
    end

    // One shift-add-3 step over the {bcd, bin} register
    always_comb begin
        shift_next = {bcd_adjust(shreg[25:10]), shreg[9:0]} << 1;
    end

    // Operation sequencer. Operands and opcode are latched on the way into
    // LATCH so they are already stable while LATCH is active; digits are loaded
    // on the way into DONE so they are valid in the same cycle as the done pulse.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= ST_IDLE;
            op_code  <= OP_PASS;
            op_a     <= '0;
            op_b     <= '0;
            LEDR     <= '0;
            minus    <= 1'b0;
            dig0     <= '0;
            dig1     <= '0;
            dig2     <= '0;
            dig3     <= '0;
            wait_cnt <= '0;
            iter     <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|press) begin
                        op_a    <= SW[9:5];
                        op_b    <= SW[4:0];
                        op_code <= sel_op;
                        state   <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    wait_cnt <= WW'(DP_LAT - 1);
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt - WW'(1);
                    end
                end
                ST_CAPTURE: begin
                    LEDR  <= res_in;
                    minus <= neg_in;
                    shreg <= {16'd0, res_in};
                    iter  <= '0;
                    state <= ST_CONVERT;
                end
                ST_CONVERT: begin
                    shreg <= shift_next;
                    if (iter == 4'(BCD_ITER - 1)) begin
                        dig0  <= shift_next[13:10];
                        dig1  <= shift_next[17:14];
                        dig2  <= shift_next[21:18];
                        dig3  <= minus ? DIG_DASH : shift_next[25:22];
                        state <= ST_DONE;
                    end else begin
                        iter <= iter + 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_LATCH) || (state == ST_WAIT) ||
                  (state == ST_CAPTURE) || (state == ST_CONVERT);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl with a behavioural datapath and a
// reference model computing results and decimal digits arithmetically.
module tb_calc_seq_ctrl;

    localparam int DEB = 4;
    localparam int LAT = 1;

    logic       CLOCK_50;
    logic       RESET_N;
    logic [9:0] SW;
    logic [2:0] KEY;
    logic [1:0] op_code;
    logic [4:0] op_a;
    logic [4:0] op_b;
    logic [9:0] res_in;
    logic       neg_in;
    logic [9:0] LEDR;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic [3:0] dig3;
    logic       minus;
    logic       busy;
    logic       done;

    logic       ovr_en;
    logic [9:0] ovr_val;

    int vectors;
    int miscompares;

    calc_seq_ctrl #(
        .DEB_CYCLES(DEB),
        .DP_LAT    (LAT)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .RESET_N (RESET_N),
        .SW      (SW),
        .KEY     (KEY),
        .op_code (op_code),
        .op_a    (op_a),
        .op_b    (op_b),
        .res_in  (res_in),
        .neg_in  (neg_in),
        .LEDR    (LEDR),
        .dig0    (dig0),
        .dig1    (dig1),
        .dig2    (dig2),
        .dig3    (dig3),
        .minus   (minus),
        .busy    (busy),
        .done    (done)
    );

    // 100 MHz bench clock
    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // Behavioural combinational datapath, with an override to reach 1000..1023
    always_comb begin
        res_in = '0;
        neg_in = 1'b0;
        if (ovr_en) begin
            res_in = ovr_val;
        end else begin
            case (op_code)
                2'd0: res_in = 10'(op_a) + 10'(op_b);
                2'd1: begin
                    neg_in = (op_a < op_b);
                    res_in = neg_in ? 10'(op_b - op_a) : 10'(op_a - op_b);
                end
                2'd2: res_in = 10'(op_a) * 10'(op_b);
                default: res_in = 10'(op_a);
            endcase
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int modelRes(input int op, input int a, input int b);
        case (op)
            0: return a + b;
            1: return (a >= b) ? a - b : b - a;
            default: return a * b;
        endcase
    endfunction

    // Drives one key sequence while watching busy/done for a fixed window
    task automatic applyStimulus(input logic [2:0] key_mask, input int hold,
                                 input logic [2:0] late_mask, input int late_start,
                                 input logic [4:0] a, input logic [4:0] b,
                                 output int latency, output int n_done, output int busy_rise);
        int dcyc;
        int tail;
        logic [2:0] k;
        busy_rise = -1;
        dcyc = -1;
        n_done = 0;
        tail = hold + 30;
        if (late_start >= 0 && late_start + 40 > tail) tail = late_start + 40;
        SW = {a, b};
        for (int i = 0; i < tail; i++) begin
            @(negedge CLOCK_50);
            if (busy && busy_rise < 0) busy_rise = i;
            if (done) begin
                n_done++;
                if (dcyc < 0) dcyc = i;
            end
            k = 3'b111;
            if (i < hold) k = k & ~key_mask;
            if (late_start >= 0 && i >= late_start && i < late_start + 10) k = k & ~late_mask;
            KEY = k;
        end
        KEY = 3'b111;
        latency = (busy_rise >= 0 && dcyc >= 0) ? dcyc - busy_rise : -1;
    endtask

    task automatic checkResult(input string tag, input int exp_op, input int a, input int b,
                               input int exp_res, input bit exp_neg,
                               input int latency, input int n_done);
        checkOutput({tag, "_ndone"}, n_done, 1);
        checkOutput({tag, "_latency"}, latency, LAT + 12);
        checkOutput({tag, "_opcode"}, int'(op_code), exp_op);
        checkOutput({tag, "_op_a"}, int'(op_a), a);
        checkOutput({tag, "_op_b"}, int'(op_b), b);
        checkOutput({tag, "_ledr"}, int'(LEDR), exp_res);
        checkOutput({tag, "_minus"}, int'(minus), int'(exp_neg));
        checkOutput({tag, "_dig0"}, int'(dig0), exp_res % 10);
        checkOutput({tag, "_dig1"}, int'(dig1), (exp_res / 10) % 10);
        checkOutput({tag, "_dig2"}, int'(dig2), (exp_res / 100) % 10);
        checkOutput({tag, "_dig3"}, int'(dig3), exp_neg ? 10 : exp_res / 1000);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_opcode"}, int'(op_code), 3);
        checkOutput({tag, "_op_a"}, int'(op_a), 0);
        checkOutput({tag, "_op_b"}, int'(op_b), 0);
        checkOutput({tag, "_ledr"}, int'(LEDR), 0);
        checkOutput({tag, "_digits"}, int'({dig3, dig2, dig1, dig0}), 0);
        checkOutput({tag, "_minus"}, int'(minus), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
    endtask

    // Main test sequence
    initial begin
        int lat;
        int nd;
        int br;
        int a;
        int b;
        int key;
        int rise;
        vectors = 0;
        miscompares = 0;
        ovr_en = 1'b0;
        ovr_val = '0;
        SW = '0;
        KEY = 3'b111;
        RESET_N = 1'b1;
        #2 RESET_N = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        checkIdleOutputs("reset");
        RESET_N = 1'b1;
        repeat (5) @(negedge CLOCK_50);

        applyStimulus(3'b001, 10, 3'b000, -1, 5'd3, 5'd5, lat, nd, br);
        checkResult("add", 0, 3, 5, 8, 1'b0, lat, nd);

        // Reset during CONVERT aborts and clears everything
        SW = {5'd9, 5'd4};
        KEY = 3'b110;
        rise = -1;
        for (int i = 0; i < 40 && rise < 0; i++) begin
            @(negedge CLOCK_50);
            if (busy) rise = i;
        end
        KEY = 3'b111;
        checkOutput("rst_busy_seen", int'(rise >= 0), 1);
        repeat (5) @(negedge CLOCK_50);
        checkOutput("rst_in_convert_busy", int'(busy), 1);
        RESET_N = 1'b0;
        #1;
        checkIdleOutputs("rst_mid");
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        nd = 0;
        br = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLOCK_50);
            if (done) nd++;
            if (busy) br++;
        end
        checkOutput("rst_after_done", nd, 0);
        checkOutput("rst_after_busy", br, 0);

        applyStimulus(3'b010, 10, 3'b000, -1, 5'd3, 5'd5, lat, nd, br);
        checkResult("sub_neg", 1, 3, 5, 2, 1'b1, lat, nd);

        applyStimulus(3'b100, 10, 3'b000, -1, 5'd31, 5'd31, lat, nd, br);
        checkResult("mul_max", 2, 31, 31, 961, 1'b0, lat, nd);

        applyStimulus(3'b010, 2, 3'b000, -1, 5'd7, 5'd1, lat, nd, br);
        checkOutput("short_ndone", nd, 0);
        checkOutput("short_busy", br, -1);

        applyStimulus(3'b101, 10, 3'b000, -1, 5'd7, 5'd9, lat, nd, br);
        checkResult("prio", 0, 7, 9, 16, 1'b0, lat, nd);

        applyStimulus(3'b001, 100, 3'b000, -1, 5'd20, 5'd11, lat, nd, br);
        checkResult("hold", 0, 20, 11, 31, 1'b0, lat, nd);

        applyStimulus(3'b001, 10, 3'b100, 10, 5'd12, 5'd6, lat, nd, br);
        checkResult("busy_drop", 0, 12, 6, 18, 1'b0, lat, nd);

        ovr_en = 1'b1;
        ovr_val = 10'd1000;
        applyStimulus(3'b001, 10, 3'b000, -1, 5'd1, 5'd2, lat, nd, br);
        checkResult("res1000", 0, 1, 2, 1000, 1'b0, lat, nd);
        ovr_val = 10'd1023;
        applyStimulus(3'b001, 10, 3'b000, -1, 5'd2, 5'd1, lat, nd, br);
        checkResult("res1023", 0, 2, 1, 1023, 1'b0, lat, nd);
        ovr_en = 1'b0;

        for (int t = 0; t < 12; t++) begin
            a = int'($urandom_range(0, 31));
            b = int'($urandom_range(0, 31));
            key = int'($urandom_range(0, 2));
            applyStimulus(3'(1 << key), 10, 3'b000, -1, 5'(a), 5'(b), lat, nd, br);
            checkResult($sformatf("rand%0d", t), key, a, b, modelRes(key, a, b),
                        (key == 1) && (a < b), lat, nd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
